vector_checker: RTL and testbench
=================================

// Module: vector_checker
// PURPOSE
//  Response-side partner to the timed testbench stimulus driver: it consumes expected-output vectors and samples DUT outputs.
//  - Each vector is accepted over a valid/ready handshake.
//  - After a programmable settle delay it samples the DUT outputs and compares them under a mask.
//  - It keeps pass/fail tallies and records the first failing step.
//  - Sits beside Main's instance; the simulator reports its status outputs.
// PARAMETERS
//  WIDTH   2  number of DUT output bits checked (bit1=X/o1, bit0=Y/o2 in the example design)
//  SETTLE  2  cycles waited after acceptance before sampling dut_out (0 allowed)
//  CNT_W   8  width of step index and pass/fail counters
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  exp_valid       in   1      expected vector present
//  exp_ready       out  1      checker can accept a vector
//  exp_data        in   WIDTH  expected DUT output
//  exp_mask        in   WIDTH  1 = bit is compared, 0 = don't care
//  exp_last        in   1      final vector of the test
//  dut_out         in   WIDTH  live DUT outputs
//  pass_cnt        out  CNT_W  vectors that matched
//  fail_cnt        out  CNT_W  vectors that mismatched
//  first_fail_vld  out  1      a failure has been recorded
//  first_fail_idx  out  CNT_W  step index of first failure
//  first_fail_got  out  WIDTH  dut_out sampled at first failure
//  mismatch        out  1      one-cycle pulse per failing compare
//  done            out  1      last vector checked
//  all_pass        out  1      done && fail_cnt==0
// BEHAVIOUR
//  Reset
//  - All outputs 0 on the edge where rst=1, except exp_ready, which reads 1 the cycle after.
//  - Reset mid-operation discards the latched vector and clears all counts and the step index.
//  FSM states: IDLE, SETTLE, COMPARE, DONE.
//  IDLE
//  - exp_ready=1.
//  - On an edge with exp_valid&&exp_ready: latch exp_data, exp_mask and exp_last.
//  - Then go to SETTLE with settle count=SETTLE, or straight to COMPARE if SETTLE==0.
//  SETTLE
//  - exp_ready=0; count decrements each cycle.
//  - Exactly SETTLE cycles are spent here, then COMPARE.
//  COMPARE (one cycle)
//  - exp_ready=0.
//  - hit = ((dut_out ^ exp_data) & exp_mask) == 0, evaluated on dut_out in this cycle.
//  - At the closing edge, hit: pass_cnt+1.
//  - At the closing edge, miss: fail_cnt+1 and mismatch=1 for the next cycle.
//  - On the first miss only, also set first_fail_vld/idx/got (all later misses ignored).
//  - Step index increments (wraps modulo 2^CNT_W).
//  - Next state is DONE if the latched last=1, else IDLE.
//  Latency
//  - Counter update is visible SETTLE+1 edges after the acceptance edge.
//  - Minimum vector period is SETTLE+2 cycles.
//  DONE
//  - done=1, exp_ready=0, all_pass=(fail_cnt==0); held until rst.
//  - exp_valid is ignored.
//  Arithmetic and handshake rules
//  - pass_cnt and fail_cnt saturate at 2^CNT_W-1 (no wrap); the step index wraps.
//  - exp_valid while exp_ready=0 is ignored; the producer holds it.
//  - Data is sampled only on the handshake edge.
//  - A vector with exp_mask=0 always counts as a pass.
// TESTING
//  1 Golden AND/OR, WIDTH=2, SETTLE=2, DUT correct.
//    - exp {00,01,01,11}, last on the 4th vector.
//    - Expect pass_cnt=4, fail_cnt=0, done=1, all_pass=1, mismatch never high.
//  2 Fault injection: 3rd vector exp=01, DUT forced 00.
//    - Expect fail_cnt=1, first_fail_idx=2, first_fail_got=00.
//    - Expect mismatch high exactly one cycle, all_pass=0 at done.
//  3 Mask: exp=11, mask=01, dut_out=01.
//    - Expect pass_cnt+1, no mismatch.
//  4 Settle timing, SETTLE=2.
//    - dut_out reaches expected value in the 2nd SETTLE cycle: pass.
//    - dut_out reaches it one cycle after COMPARE: fail.
//    - Also run SETTLE=0: counter updates 1 edge after acceptance.
//  5 Saturation, CNT_W=3: 9 failing vectors.
//    - Expect fail_cnt=7, first_fail_idx=0.
//    - Step index wraps to 1; first_fail_* unchanged.
//  6 Mid-operation events.
//    - rst asserted during SETTLE: next cycle all counts 0, exp_ready=1, vector not counted.
//    - exp_valid held during DONE: no change.

Source files
------------

// File: rtl/vector_checker.sv
// Expected-vector checker: accepts a vector, waits SETTLE cycles,
// then compares dut_out under a mask and keeps pass/fail tallies.
module vector_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic             exp_last,
  input  logic [WIDTH-1:0] dut_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_got,
  output logic             mismatch,
  output logic             done,
  output logic             all_pass
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic             last_q;
  logic [SW-1:0]    cnt;
  logic [CNT_W-1:0] step;
  logic             hit;

  assign hit = ((dut_out ^ data_q) & mask_q) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      exp_ready      <= 1'b1;
      data_q         <= '0;
      mask_q         <= '0;
      last_q         <= 1'b0;
      cnt            <= '0;
      step           <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      mismatch       <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (exp_valid) begin
            data_q    <= exp_data;
            mask_q    <= exp_mask;
            last_q    <= exp_last;
            exp_ready <= 1'b0;
            if (SETTLE == 0) begin
              state <= S_COMPARE;
            end else begin
              state <= S_SETTLE;
              cnt   <= SW'(SETTLE);
            end
          end
        end
        S_SETTLE: begin
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1))
            state <= S_COMPARE;
        end
        S_COMPARE: begin
          step <= step + CNT_W'(1);
          if (hit) begin
            if (pass_cnt != CMAX)
              pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != CMAX)
              fail_cnt <= fail_cnt + CNT_W'(1);
            mismatch <= 1'b1;
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= step;
              first_fail_got <= dut_out;
            end
          end
          if (last_q) begin
            state    <= S_DONE;
            done     <= 1'b1;
            all_pass <= hit && (fail_cnt == '0);
          end else begin
            state     <= S_IDLE;
            exp_ready <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: two instances (SETTLE=2/CNT_W=8
// and SETTLE=0/CNT_W=3) driven with directed and random vectors.
module tb_vector_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vld[2], rdy[2], lst[2], ffv[2];
  logic       mm[2], dn[2], ap[2];
  logic [1:0] dat[2], msk[2], dut[2], ffg[2];
  logic [7:0] pc[2], fc[2], fi[2];
  logic [2:0] pc_b, fc_b, fi_b;

  assign pc[1] = {5'd0, pc_b};
  assign fc[1] = {5'd0, fc_b};
  assign fi[1] = {5'd0, fi_b};

  vector_checker #(.WIDTH(2), .SETTLE(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst),
    .exp_valid(vld[0]), .exp_ready(rdy[0]),
    .exp_data(dat[0]), .exp_mask(msk[0]),
    .exp_last(lst[0]), .dut_out(dut[0]),
    .pass_cnt(pc[0]), .fail_cnt(fc[0]),
    .first_fail_vld(ffv[0]), .first_fail_idx(fi[0]),
    .first_fail_got(ffg[0]), .mismatch(mm[0]),
    .done(dn[0]), .all_pass(ap[0])
  );

  vector_checker #(.WIDTH(2), .SETTLE(0), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst),
    .exp_valid(vld[1]), .exp_ready(rdy[1]),
    .exp_data(dat[1]), .exp_mask(msk[1]),
    .exp_last(lst[1]), .dut_out(dut[1]),
    .pass_cnt(pc_b), .fail_cnt(fc_b),
    .first_fail_vld(ffv[1]), .first_fail_idx(fi_b),
    .first_fail_got(ffg[1]), .mismatch(mm[1]),
    .done(dn[1]), .all_pass(ap[1])
  );

  typedef struct {
    int pass;
    int fail;
    bit ffv;
    int ffidx;
    int ffgot;
    bit mm;
    bit done;
    bit allp;
  } exp_t;

  exp_t q[2][$];

  int checks = 0;
  int errors = 0;
  int settle_of[2] = '{2, 0};
  int max_of[2]    = '{255, 7};

  int m_pass[2], m_fail[2], m_step[2];
  int m_ffidx[2], m_ffgot[2], m_miss[2];
  bit m_ffv[2];
  int mm_seen[2];

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, got, want, $time);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_pass[d]  = 0;
      m_fail[d]  = 0;
      m_step[d]  = 0;
      m_ffv[d]   = 1'b0;
      m_ffidx[d] = 0;
      m_ffgot[d] = 0;
      q[d].delete();
    end
  endtask

  // Reference: one vector judged on the value seen at compare time.
  task automatic model(int d, logic [1:0] e, logic [1:0] m,
                       logic [1:0] g, bit last);
    exp_t x;
    bit hit;
    hit = ((g ^ e) & m) == 2'b00;
    if (hit) begin
      if (m_pass[d] < max_of[d]) m_pass[d]++;
    end else begin
      if (m_fail[d] < max_of[d]) m_fail[d]++;
      m_miss[d]++;
      if (!m_ffv[d]) begin
        m_ffv[d]   = 1'b1;
        m_ffidx[d] = m_step[d];
        m_ffgot[d] = int'(g);
      end
    end
    m_step[d] = (m_step[d] + 1) % (max_of[d] + 1);
    x.pass  = m_pass[d];
    x.fail  = m_fail[d];
    x.ffv   = m_ffv[d];
    x.ffidx = m_ffidx[d];
    x.ffgot = m_ffgot[d];
    x.mm    = !hit;
    x.done  = last;
    x.allp  = last && (m_fail[d] == 0);
    q[d].push_back(x);
  endtask

  // Monitor: a compare has completed when ready or done rises.
  bit prev_r[2], prev_d[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (mm[d] === 1'b1) mm_seen[d]++;
      if (rst) begin
        prev_r[d] = 1'b1;
        prev_d[d] = 1'b0;
      end else begin
        if ((rdy[d] && !prev_r[d]) || (dn[d] && !prev_d[d])) begin
          if (q[d].size() == 0) begin
            chk("unexpected_result", d, -1);
          end else begin
            e = q[d].pop_front();
            chk("pass_cnt", int'(pc[d]), e.pass);
            chk("fail_cnt", int'(fc[d]), e.fail);
            chk("ff_vld", int'(ffv[d]), int'(e.ffv));
            chk("ff_idx", int'(fi[d]), e.ffidx);
            chk("ff_got", int'(ffg[d]), e.ffgot);
            chk("mismatch", int'(mm[d]), int'(e.mm));
            chk("done", int'(dn[d]), int'(e.done));
            chk("all_pass", int'(ap[d]), int'(e.allp));
          end
        end
        prev_r[d] = rdy[d];
        prev_d[d] = dn[d];
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", int'(rdy[d]), 1);
      chk("rst_pass", int'(pc[d]), 0);
      chk("rst_fail", int'(fc[d]), 0);
      chk("rst_ffv", int'(ffv[d]), 0);
      chk("rst_done", int'(dn[d]), 0);
      chk("rst_allp", int'(ap[d]), 0);
      chk("rst_mm", int'(mm[d]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
  endtask

  // Wait for ready (bounded), pass the handshake edge, scramble inputs.
  task automatic accept(int d);
    int n = 0;
    vld[d] = 1'b1;
    @(negedge clk);
    while (rdy[d] !== 1'b1) begin
      n++;
      if (n > 50) begin
        $display("FAIL handshake_timeout: dut %0d ready never seen", d);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    dat[d] = 2'($urandom);
    msk[d] = 2'($urandom);
    lst[d] = 1'($urandom);
    chk("ready_low_after_accept", int'(rdy[d]), 0);
  endtask

  // dut_out = early until sw cycles after acceptance, then late.
  task automatic send(int d, logic [1:0] e, logic [1:0] m, bit last,
                      logic [1:0] early, logic [1:0] late, int sw);
    logic [1:0] g;
    g = (sw <= settle_of[d]) ? late : early;
    model(d, e, m, g, last);
    dat[d] = e;
    msk[d] = m;
    lst[d] = last;
    dut[d] = early;
    accept(d);
    if (sw == 0) dut[d] = late;
    for (int c = 1; c <= settle_of[d] + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == sw) dut[d] = late;
      if (c <= settle_of[d])
        chk("ready_in_settle", int'(rdy[d]), 0);
      else
        chk("result_latency", int'(rdy[d] | dn[d]), 1);
    end
  endtask

  initial begin
    logic [1:0] gold[4];
    logic [1:0] e, m, g;
    gold = '{2'b00, 2'b01, 2'b01, 2'b11};
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; lst[d] = 1'b0;
      dat[d] = '0; msk[d] = '0; dut[d] = '0;
      m_miss[d] = 0; mm_seen[d] = 0;
    end
    do_reset();

    // Golden run, DUT correct.
    for (int i = 0; i < 4; i++)
      send(0, gold[i], 2'b11, i == 3, gold[i], gold[i], 0);
    repeat (2) @(negedge clk);
    chk("golden_pass", int'(pc[0]), 4);
    chk("golden_allp", int'(ap[0]), 1);
    do_reset();

    // Fault on 3rd vector; then exp_valid held in DONE.
    for (int i = 0; i < 4; i++) begin
      g = (i == 2) ? 2'b00 : gold[i];
      send(0, gold[i], 2'b11, i == 3, g, g, 0);
    end
    dat[0] = 2'b11; msk[0] = 2'b11; vld[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("done_hold_pass", int'(pc[0]), m_pass[0]);
    chk("done_hold_fail", int'(fc[0]), 1);
    chk("done_hold_ffidx", int'(fi[0]), 2);
    chk("done_hold_ffgot", int'(ffg[0]), 0);
    chk("done_hold_ready", int'(rdy[0]), 0);
    chk("done_hold_done", int'(dn[0]), 1);
    chk("done_hold_allp", int'(ap[0]), 0);
    vld[0] = 1'b0;
    do_reset();

    // Mask and settle timing.
    send(0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 0);
    send(0, 2'b10, 2'b00, 0, 2'b01, 2'b01, 0);
    send(0, 2'b10, 2'b11, 0, 2'b01, 2'b10, 1);
    send(0, 2'b10, 2'b11, 0, 2'b01, 2'b10, 2);
    send(0, 2'b10, 2'b11, 0, 2'b01, 2'b10, 3);

    // Reset during SETTLE discards the vector.
    dat[0] = 2'b11; msk[0] = 2'b11; lst[0] = 1'b0; dut[0] = 2'b00;
    accept(0);
    @(posedge clk);
    #1;
    do_reset();
    send(0, 2'b11, 2'b11, 0, 2'b11, 2'b11, 0);
    chk("after_mid_reset_pass", int'(pc[0]), 1);

    // Random vectors on instance A.
    for (int i = 0; i < 40; i++) begin
      e = 2'($urandom); m = 2'($urandom);
      g = ($urandom_range(0, 1) == 1) ? e : 2'($urandom);
      send(0, e, m, 0, 2'($urandom), g,
           int'($urandom_range(0, 3)));
    end
    send(0, 2'b01, 2'b11, 1, 2'b01, 2'b01, 0);

    // Instance B: SETTLE=0, saturation and wrap at CNT_W=3.
    send(1, 2'b11, 2'b11, 0, 2'b11, 2'b11, 0);
    do_reset();
    for (int i = 0; i < 9; i++)
      send(1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0);
    chk("sat_fail", int'(fc[1]), 7);
    chk("sat_ffidx", int'(fi[1]), 0);
    send(1, 2'b01, 2'b11, 0, 2'b10, 2'b10, 0);
    chk("wrap_ffgot", int'(ffg[1]), 0);
    for (int i = 0; i < 10; i++) begin
      e = 2'($urandom);
      send(1, e, 2'($urandom), 0, 2'($urandom), e,
           int'($urandom_range(0, 1)));
    end
    send(1, 2'b10, 2'b11, 1, 2'b10, 2'b10, 0);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("mismatch_pulses", mm_seen[d], m_miss[d]);
      chk("queue_drained", q[d].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
